// File: rtl/mem_seq_pkg.sv
// rtl/mem_seq_pkg.sv - op codes, widths and FSM states for the memory sequencer
// Pair states are only present when MEM_SEQ_PAIR_EN is defined.
package mem_seq_pkg;

  localparam int WADDR_W = 15;
  localparam int DATA_W  = 16;
  localparam int REG_W   = 4;

  typedef enum logic [1:0] {
    OP_LD  = 2'b00,
    OP_ST  = 2'b01,
    OP_LDP = 2'b10,
    OP_STP = 2'b11
  } op_t;

`ifdef MEM_SEQ_PAIR_EN
  typedef enum logic [2:0] {
    S_IDLE, S_RD0, S_RD1, S_RDW, S_WR0, S_WR1
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_RD0, S_RDW, S_WR0
  } state_t;
`endif

  function automatic logic is_store(input op_t op);
    return (op == OP_ST) || (op == OP_STP);
  endfunction

  function automatic logic is_pair(input op_t op);
    return (op == OP_LDP) || (op == OP_STP);
  endfunction

endpackage

// File: rtl/mem_seq.sv
// rtl/mem_seq.sv - load/store sequencer between execute stage and a 1-cycle-latency RAM
// MEM_SEQ_PAIR_EN enables ldp/stp; without it pair ops pulse err and are dropped.
module mem_seq
  import mem_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [15:0]        req_addr,
  input  logic [DATA_W-1:0]  req_wdata0,
  input  logic [DATA_W-1:0]  req_wdata1,
  input  logic [REG_W-1:0]   req_rt,
  input  logic               flush,
  output logic [WADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               mem_wen,
  output logic [WADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               wb_valid,
  output logic [REG_W-1:0]   wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  output logic               stall,
  output logic               err
);

  state_t             state, state_nx;
  op_t                op;
  logic               accept;
  logic [WADDR_W-1:0] a_q;
  logic [DATA_W-1:0]  wd0_q;
  logic [REG_W-1:0]   rt_q;
  logic [REG_W-1:0]   rt_inc;
  logic               pair_q;
  logic               unused_bits;

`ifdef MEM_SEQ_PAIR_EN
  logic [DATA_W-1:0]  wd1_q;
  logic [WADDR_W-1:0] a_inc;
  assign a_inc       = a_q + 15'd1;
  assign unused_bits = req_addr[0];
`else
  assign unused_bits = ^{req_addr[0], req_wdata1};
`endif

  assign op        = op_t'(req_op);
  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid & req_ready & ~flush;
  assign rt_inc    = rt_q + 4'd1;
  // stall covers the accept cycle too, so execute holds until the last busy cycle
  assign stall     = (state_nx != S_IDLE) | (req_valid & ~req_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_q    <= '0;
      wd0_q  <= '0;
      rt_q   <= '0;
      pair_q <= 1'b0;
`ifdef MEM_SEQ_PAIR_EN
      wd1_q  <= '0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        a_q    <= req_addr[15:1];
        wd0_q  <= req_wdata0;
        rt_q   <= req_rt;
        pair_q <= is_pair(op);
`ifdef MEM_SEQ_PAIR_EN
        wd1_q  <= req_wdata1;
`endif
      end
    end
  end

  always_comb begin
    state_nx  = state;
    mem_raddr = '0;
    mem_wen   = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    wb_valid  = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    err       = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nx = is_store(op) ? S_WR0 : S_RD0;
      end
      S_RD0: begin
`ifdef MEM_SEQ_PAIR_EN
        mem_raddr = a_q;
        state_nx  = pair_q ? S_RD1 : S_RDW;
`else
        if (pair_q) begin
          err      = 1'b1;
          state_nx = S_IDLE;
        end else begin
          mem_raddr = a_q;
          state_nx  = S_RDW;
        end
`endif
      end
`ifdef MEM_SEQ_PAIR_EN
      S_RD1: begin
        mem_raddr = a_inc;
        wb_valid  = 1'b1;
        wb_addr   = rt_q;
        wb_data   = mem_rdata;
        state_nx  = S_RDW;
      end
`endif
      S_RDW: begin
        wb_valid = 1'b1;
        wb_addr  = pair_q ? rt_inc : rt_q;
        wb_data  = mem_rdata;
        state_nx = S_IDLE;
      end
      S_WR0: begin
`ifdef MEM_SEQ_PAIR_EN
        mem_wen   = 1'b1;
        mem_waddr = a_q;
        mem_wdata = wd0_q;
        state_nx  = pair_q ? S_WR1 : S_IDLE;
`else
        state_nx = S_IDLE;
        if (pair_q) begin
          err = 1'b1;
        end else begin
          mem_wen   = 1'b1;
          mem_waddr = a_q;
          mem_wdata = wd0_q;
        end
`endif
      end
`ifdef MEM_SEQ_PAIR_EN
      S_WR1: begin
        mem_wen   = 1'b1;
        mem_waddr = a_inc;
        mem_wdata = wd1_q;
        state_nx  = S_IDLE;
      end
`endif
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_seq.sv
// tb/tb_mem_seq.sv - randomized and directed bench for mem_seq against a per-cycle schedule model
// Pair-op expectations follow MEM_SEQ_PAIR_EN.
module tb_mem_seq;

`ifdef MEM_SEQ_PAIR_EN
  localparam bit PAIR = 1'b1;
`else
  localparam bit PAIR = 1'b0;
`endif
  localparam int NC = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_addr;
  logic [15:0] req_wdata0;
  logic [15:0] req_wdata1;
  logic [3:0]  req_rt;
  logic        flush;
  logic [14:0] mem_raddr;
  logic [15:0] mem_rdata;
  logic        mem_wen;
  logic [14:0] mem_waddr;
  logic [15:0] mem_wdata;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        stall;
  logic        err;

  mem_seq dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata0(req_wdata0),
    .req_wdata1(req_wdata1), .req_rt(req_rt), .flush(flush),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_wen(mem_wen),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM seen by the DUT, and the model's own picture of memory contents
  logic [15:0] ram    [32768];
  logic [15:0] shadow [32768];
  always @(posedge clk) begin
    if (mem_wen) ram[mem_waddr] <= mem_wdata;
    mem_rdata <= ram[mem_raddr];
  end

  // expected events per cycle number
  logic        e_rd   [NC];
  logic [14:0] e_raddr[NC];
  logic        e_wen  [NC];
  logic [14:0] e_waddr[NC];
  logic [15:0] e_wdata[NC];
  logic        e_wb   [NC];
  logic [3:0]  e_wba  [NC];
  logic [15:0] e_wbd  [NC];
  logic        e_err  [NC];
  int busy_until = -1;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req);
    end
  endtask

  task automatic clr(input int k);
    if (k < NC) begin
      e_rd[k] = 0; e_raddr[k] = 0; e_wen[k] = 0; e_waddr[k] = 0; e_wdata[k] = 0;
      e_wb[k] = 0; e_wba[k] = 0; e_wbd[k] = 0; e_err[k] = 0;
    end
  endtask

  task automatic exp_rd(input int k, input logic [14:0] a);
    if (k < NC) begin e_rd[k] = 1; e_raddr[k] = a; end
  endtask

  task automatic exp_wr(input int k, input logic [14:0] a, input logic [15:0] d);
    if (k < NC) begin e_wen[k] = 1; e_waddr[k] = a; e_wdata[k] = d; end
    shadow[a] = d;
  endtask

  task automatic exp_wb(input int k, input logic [3:0] r, input logic [15:0] d);
    if (k < NC) begin e_wb[k] = 1; e_wba[k] = r; e_wbd[k] = d; end
  endtask

  task automatic sched(input int t);
    logic [14:0] a, a1;
    logic [3:0]  r1;
    a  = req_addr[15:1];
    a1 = a + 15'd1;
    r1 = req_rt + 4'd1;
    case (req_op)
      2'b00: begin
        exp_rd(t + 1, a);
        exp_wb(t + 2, req_rt, shadow[a]);
        busy_until = t + 2;
      end
      2'b01: begin
        exp_wr(t + 1, a, req_wdata0);
        busy_until = t + 1;
      end
      2'b10: begin
        if (PAIR) begin
          exp_rd(t + 1, a);
          exp_rd(t + 2, a1);
          exp_wb(t + 2, req_rt, shadow[a]);
          exp_wb(t + 3, r1, shadow[a1]);
          busy_until = t + 3;
        end else begin
          if (t + 1 < NC) e_err[t + 1] = 1;
          busy_until = t + 1;
        end
      end
      default: begin
        if (PAIR) begin
          exp_wr(t + 1, a, req_wdata0);
          exp_wr(t + 2, a1, req_wdata1);
          busy_until = t + 2;
        end else begin
          if (t + 1 < NC) e_err[t + 1] = 1;
          busy_until = t + 1;
        end
      end
    endcase
  endtask

  always @(negedge clk) begin
    bit idle;
    bit acc;
    bit exp_stall;
    if (!rst_n) begin
      for (int k = cyc; k < cyc + 4; k++) clr(k);
      busy_until = cyc;
      chk("rst_ready", req_ready, 1);
      chk("rst_wen", mem_wen, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_stall", stall, 0);
      chk("rst_raddr", mem_raddr, 0);
      chk("rst_waddr", mem_waddr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_wb_addr", wb_addr, 0);
      chk("rst_wb_data", wb_data, 0);
    end else begin
      idle = (cyc > busy_until);
      acc  = idle && req_valid && !flush;
      if (acc) sched(cyc);
      if (acc)       exp_stall = 1;
      else if (idle) exp_stall = 0;
      else           exp_stall = (cyc < busy_until) || req_valid;
      chk("ready", req_ready, idle);
      chk("stall", stall, exp_stall);
      chk("wen", mem_wen, e_wen[cyc]);
      if (e_wen[cyc]) begin
        chk("waddr", mem_waddr, e_waddr[cyc]);
        chk("wdata", mem_wdata, e_wdata[cyc]);
      end
      if (e_rd[cyc]) chk("raddr", mem_raddr, e_raddr[cyc]);
      chk("wb_valid", wb_valid, e_wb[cyc]);
      if (e_wb[cyc]) begin
        chk("wb_addr", wb_addr, e_wba[cyc]);
        chk("wb_data", wb_data, e_wbd[cyc]);
      end
      chk("err", err, e_err[cyc]);
    end
  end

  task automatic put(input int a, input logic [15:0] d);
    ram[a]    = d;
    shadow[a] = d;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // presents one op for a single cycle; returns #1 into the cycle after it
  task automatic present(input logic [1:0] op, input logic [15:0] addr, input logic [3:0] rt,
                         input logic [15:0] w0, input logic [15:0] w1, input logic fl);
    @(posedge clk);
    #1;
    req_valid = 1; req_op = op; req_addr = addr; req_rt = rt;
    req_wdata0 = w0; req_wdata1 = w1; flush = fl;
    @(posedge clk);
    #1;
    req_valid = 0; flush = 0;
  endtask

  function automatic logic [15:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 7)      return 16'($urandom_range(0, 63));
    else if (sel < 9) return 16'($urandom_range(16'hFFF0, 16'hFFFF));
    else              return 16'($urandom);
  endfunction

  initial begin
    rst_n = 0; req_valid = 0; req_op = 0; req_addr = 0; req_wdata0 = 0;
    req_wdata1 = 0; req_rt = 0; flush = 0;
    for (int k = 0; k < NC; k++) clr(k);
    for (int i = 0; i < 32768; i++) begin
      ram[i]    = 16'($urandom);
      shadow[i] = ram[i];
    end
    put(8, 16'hBEEF);
    put(16'h10, 16'hAAAA);
    put(16'h11, 16'h5555);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    gap(2);

    // ld 0x0010 -> rt 3
    present(2'b00, 16'h0010, 4'd3, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    chk("lit_ld_raddr", mem_raddr, 15'h0008);
    chk("lit_ld_stall_t1", stall, 1);
    @(negedge clk);
    chk("lit_ld_wb_valid", wb_valid, 1);
    chk("lit_ld_wb_addr", wb_addr, 4'd3);
    chk("lit_ld_wb_data", wb_data, 16'hBEEF);
    chk("lit_ld_stall_t2", stall, 0);
    gap(3);

    // stp at top of memory: second word wraps to 0
    present(2'b11, 16'hFFFE, 4'd0, 16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
`ifdef MEM_SEQ_PAIR_EN
    chk("lit_stp_wen0", mem_wen, 1);
    chk("lit_stp_waddr0", mem_waddr, 15'h7FFF);
    chk("lit_stp_wdata0", mem_wdata, 16'h1111);
    @(negedge clk);
    chk("lit_stp_wen1", mem_wen, 1);
    chk("lit_stp_waddr1", mem_waddr, 15'h0000);
    chk("lit_stp_wdata1", mem_wdata, 16'h2222);
`else
    chk("lit_stp_err", err, 1);
    chk("lit_stp_nowen", mem_wen, 0);
    @(negedge clk);
    chk("lit_stp_ready_t2", req_ready, 1);
    chk("lit_stp_nowen_t2", mem_wen, 0);
`endif
    gap(3);

    // ldp with rt=F: second writeback wraps to register 0
    present(2'b10, 16'h0020, 4'hF, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
`ifdef MEM_SEQ_PAIR_EN
    chk("lit_ldp_raddr0", mem_raddr, 15'h0010);
    @(negedge clk);
    chk("lit_ldp_raddr1", mem_raddr, 15'h0011);
    chk("lit_ldp_wb0_addr", wb_addr, 4'hF);
    chk("lit_ldp_wb0_data", wb_data, 16'hAAAA);
    @(negedge clk);
    chk("lit_ldp_wb1_valid", wb_valid, 1);
    chk("lit_ldp_wb1_addr", wb_addr, 4'h0);
    chk("lit_ldp_wb1_data", wb_data, 16'h5555);
`else
    chk("lit_ldp_err", err, 1);
    chk("lit_ldp_nowb", wb_valid, 0);
`endif
    gap(3);

    // flush in IDLE blocks the accept
    present(2'b01, 16'h0030, 4'd0, 16'h7777, 16'h0, 1'b1);
    @(negedge clk);
    chk("lit_flush_nowen", mem_wen, 0);
    chk("lit_flush_ready", req_ready, 1);
    gap(3);

    // flush while busy is ignored
    present(2'b11, 16'h0040, 4'd0, 16'h3333, 16'h4444, 1'b0);
    req_valid = 1; req_op = 2'b00; flush = 1;
    @(negedge clk);
    @(posedge clk);
    #1;
    req_valid = 0; flush = 0;
    @(negedge clk);
`ifdef MEM_SEQ_PAIR_EN
    chk("lit_flushbusy_wen1", mem_wen, 1);
    chk("lit_flushbusy_waddr1", mem_waddr, 15'h0021);
    chk("lit_flushbusy_wdata1", mem_wdata, 16'h4444);
`else
    chk("lit_flushbusy_ready", req_ready, 1);
`endif
    gap(3);

    // reset in the middle of ldp, then a normal ld
    present(2'b10, 16'h0050, 4'd5, 16'h0, 16'h0, 1'b0);
    @(posedge clk);
    #1 rst_n = 0;
    @(negedge clk);
    chk("lit_rst_nowb", wb_valid, 0);
    chk("lit_rst_raddr", mem_raddr, 0);
    chk("lit_rst_ready", req_ready, 1);
    @(posedge clk);
    #1 rst_n = 1;
    gap(2);
    present(2'b00, 16'h0010, 4'd7, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("lit_postrst_wb_addr", wb_addr, 4'd7);
    chk("lit_postrst_wb_data", wb_data, 16'hBEEF);
    gap(3);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      @(posedge clk);
      #1;
      req_valid  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 9) == 0);
      req_op     = 2'($urandom);
      req_addr   = rand_addr();
      req_rt     = 4'($urandom);
      req_wdata0 = 16'($urandom);
      req_wdata1 = 16'($urandom);
    end
    @(posedge clk);
    #1 req_valid = 0; flush = 0;
    gap(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
